pe_window_sender: RTL and testbench

//  Producer side of the PE input handshake (o_data/o_valid -> PE i_data/i_valid, PE pe_ack -> here).

---
 rtl/pe_pkg.sv | 40 ++++
 rtl/pe_window_if.sv | 25 ++
 rtl/pe_window_sender_line_buffer.sv | 58 +++++
 rtl/pe_window_sender.sv | 154 +++++++++++++++
 tb/tb_pe_window_sender.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE window sender.
// Pure declarations; no latency.
// No flow control of its own.
package pe_pkg;

    // Default build of the block; instances override through their own parameters.
    localparam int DATA_WIDTH_DEF = 16;
    localparam int IN_CHANNEL_DEF = 16;
    localparam int KERNEL_0_DEF   = 3;
    localparam int KERNEL_1_DEF   = 3;
    localparam int PIXEL_WIDTH    = DATA_WIDTH_DEF * IN_CHANNEL_DEF;
    localparam int KERNEL_PTS     = KERNEL_0_DEF * KERNEL_1_DEF;

    typedef enum logic {
        LOAD = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // True when pos+ofs lands inside [0, size); false means a zero-pad tap.
    function automatic logic in_frame(int pos, int ofs, int size);
        int t;
        t = pos + ofs;
        return (t >= 0) && (t < size);
    endfunction

    // Circular row arithmetic; |ofs| is always smaller than modulus here.
    function automatic int wrap_add(int base, int ofs, int modulus);
        int t;
        t = base + ofs;
        if (t < 0)        t = t + modulus;
        if (t >= modulus) t = t - modulus;
        return t;
    endfunction

endpackage

// File: rtl/pe_window_if.sv
// Pixel-in / window-out handshake bundle between stream source, sender and PE.
// Wires only; no latency.
// master = sender side; slave = source/PE side.
interface pe_window_if #(
    parameter int PIX_W = 256,
    parameter int WIN_W = 2304
);
    logic [PIX_W-1:0] i_data;
    logic             i_valid;
    logic             i_ready;
    logic [WIN_W-1:0] o_data;
    logic             o_valid;
    logic             pe_ack;
    logic             frame_done;

    modport master (
        input  i_data, i_valid, pe_ack,
        output i_ready, o_data, o_valid, frame_done
    );

    modport slave (
        output i_data, i_valid, pe_ack,
        input  i_ready, o_data, o_valid, frame_done
    );
endinterface

// File: rtl/pe_window_sender_line_buffer.sv
// Circular store of KERNEL_0 pixel rows with combinational window taps and zero-pad mask.
// Write lands on the clock edge; taps are combinational and forward the pixel being written.
// No backpressure; writes are gated by the owning FSM.
module window_line_buffer
    import pe_pkg::*;
#(
    parameter int PIX_W = 256,
    parameter int K0    = 3,
    parameter int K1    = 3,
    parameter int H     = 16,
    parameter int W     = 32,
    localparam int RW   = clog2_min1(K0),
    localparam int YW   = clog2_min1(H),
    localparam int XW   = clog2_min1(W),
    localparam int PTS  = K0 * K1
)(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [RW-1:0]        wr_row,
    input  logic [XW-1:0]        wr_col,
    input  logic [PIX_W-1:0]     wr_data,
    input  logic [YW-1:0]        tap_oy,
    input  logic [XW-1:0]        tap_ox,
    input  logic [RW-1:0]        tap_row,
    output logic [PTS*PIX_W-1:0] taps
);
    localparam int AW = clog2_min1(K0 * W);
    localparam int P0 = K0 / 2;
    localparam int P1 = K1 / 2;

    logic [PIX_W-1:0] mem [K0*W];
    logic [AW-1:0]    wa;
    logic [AW-1:0]    ra;

    assign wa = AW'(int'(wr_row) * W + int'(wr_col));

    // Store accepted pixel at (row mod K0, col); contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wa] <= wr_data;
    end

    // Gather window taps, zeroing padding and bypassing a same-cycle write.
    always_comb begin
        taps = '0;
        ra   = '0;
        for (int r = 0; r < K0; r++) begin
            for (int c = 0; c < K1; c++) begin
                if (in_frame(int'(tap_oy), r - P0, H) && in_frame(int'(tap_ox), c - P1, W)) begin
                    ra = AW'(wrap_add(int'(tap_row), r - P0, K0) * W + int'(tap_ox) + c - P1);
                    if (wr_en && (ra == wa))
                        taps[(r*K1+c)*PIX_W +: PIX_W] = wr_data;
                    else
                        taps[(r*K1+c)*PIX_W +: PIX_W] = mem[ra];
                end
            end
        end
    end
endmodule

// File: rtl/pe_window_sender.sv
// Builds zero-padded stride-1 windows from a raster pixel stream and hands them to a PE.
// o_valid rises the edge after the enabling pixel is accepted; tail windows go back-to-back.
// Input stalls (i_ready=0) while a window is held; window held until pe_ack.
module pe_window_sender
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IN_CHANNEL = 16,
    parameter int KERNEL_0   = 3,
    parameter int KERNEL_1   = 3,
    parameter int IN_HEIGHT  = 16,
    parameter int IN_WIDTH   = 32
)(
    input  logic       clk,
    input  logic       rst,
    pe_window_if.master bus
);
    localparam int PIX_W = DATA_WIDTH * IN_CHANNEL;
    localparam int PTS   = KERNEL_0 * KERNEL_1;
    localparam int P0    = KERNEL_0 / 2;
    localparam int P1    = KERNEL_1 / 2;
    localparam int HW    = IN_HEIGHT * IN_WIDTH;
    localparam int CW    = $clog2(HW + 1);
    localparam int RW    = clog2_min1(KERNEL_0);
    localparam int YW    = clog2_min1(IN_HEIGHT);
    localparam int XW    = clog2_min1(IN_WIDTH);

    state_t              state;
    logic [CW-1:0]       in_idx;
    logic [CW-1:0]       out_idx;
    logic [RW-1:0]       wr_row;
    logic [XW-1:0]       wr_col;
    logic [YW-1:0]       oy;
    logic [XW-1:0]       ox;
    logic [RW-1:0]       oy_row;
    logic [YW-1:0]       nx_oy;
    logic [XW-1:0]       nx_ox;
    logic [RW-1:0]       nx_row;
    logic [YW-1:0]       tap_oy;
    logic [XW-1:0]       tap_ox;
    logic [RW-1:0]       tap_row;
    logic [PTS*PIX_W-1:0] taps;
    logic                accept;
    logic                ack;

    // Window out_n needs every pixel up to its bottom-right tap (clamped to the frame end).
    function automatic logic win_ready(int in_n, int out_n);
        int need;
        need = out_n + P0 * IN_WIDTH + P1;
        if (need > HW - 1) need = HW - 1;
        return in_n > need;
    endfunction

    assign bus.i_ready = (state == LOAD);
    assign accept      = bus.i_valid && (state == LOAD);
    assign ack         = bus.pe_ack && (state == SEND);

    // Raster successor of the current output position; in SEND the taps look one window ahead.
    always_comb begin
        nx_ox  = XW'(int'(ox) + 1);
        nx_oy  = oy;
        nx_row = oy_row;
        if (int'(ox) == IN_WIDTH - 1) begin
            nx_ox  = '0;
            nx_oy  = YW'(int'(oy) + 1);
            nx_row = RW'(wrap_add(int'(oy_row), 1, KERNEL_0));
        end
        tap_oy  = (state == SEND) ? nx_oy  : oy;
        tap_ox  = (state == SEND) ? nx_ox  : ox;
        tap_row = (state == SEND) ? nx_row : oy_row;
    end

    window_line_buffer #(
        .PIX_W (PIX_W),
        .K0    (KERNEL_0),
        .K1    (KERNEL_1),
        .H     (IN_HEIGHT),
        .W     (IN_WIDTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (bus.i_data),
        .tap_oy  (tap_oy),
        .tap_ox  (tap_ox),
        .tap_row (tap_row),
        .taps    (taps)
    );

    // LOAD/SEND control: counters, write pointer, output position and registered window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= LOAD;
            in_idx         <= '0;
            out_idx        <= '0;
            wr_row         <= '0;
            wr_col         <= '0;
            oy             <= '0;
            ox             <= '0;
            oy_row         <= '0;
            bus.o_data     <= '0;
            bus.o_valid    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        in_idx <= in_idx + CW'(1);
                        if (int'(wr_col) == IN_WIDTH - 1) begin
                            wr_col <= '0;
                            wr_row <= RW'(wrap_add(int'(wr_row), 1, KERNEL_0));
                        end else begin
                            wr_col <= wr_col + XW'(1);
                        end
                        if (win_ready(int'(in_idx) + 1, int'(out_idx))) begin
                            state       <= SEND;
                            bus.o_valid <= 1'b1;
                            bus.o_data  <= taps;
                        end
                    end
                end
                SEND: begin
                    if (ack) begin
                        if (int'(out_idx) == HW - 1) begin
                            bus.frame_done <= 1'b1;
                            bus.o_valid    <= 1'b0;
                            state          <= LOAD;
                            in_idx         <= '0;
                            out_idx        <= '0;
                            wr_row         <= '0;
                            wr_col         <= '0;
                            oy             <= '0;
                            ox             <= '0;
                            oy_row         <= '0;
                        end else begin
                            out_idx <= out_idx + CW'(1);
                            oy      <= nx_oy;
                            ox      <= nx_ox;
                            oy_row  <= nx_row;
                            if (win_ready(int'(in_idx), int'(out_idx) + 1)) begin
                                bus.o_data <= taps;
                            end else begin
                                state       <= LOAD;
                                bus.o_valid <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_window_sender.sv
// Bench for pe_window_sender: 4x4 frames through a 3x3 instance and a 1x1 instance.
// Reference windows come from direct padded-neighbourhood arithmetic over the frame array.
// PE model acks a fixed or random number of cycles after o_valid.
module tb_pe_window_sender;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pe_window_if #(.PIX_W(16), .WIN_W(144)) ifa ();
    pe_window_if #(.PIX_W(16), .WIN_W(16))  ifb ();

    pe_window_sender #(
        .DATA_WIDTH(16), .IN_CHANNEL(1), .KERNEL_0(3), .KERNEL_1(3), .IN_HEIGHT(4), .IN_WIDTH(4)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    pe_window_sender #(
        .DATA_WIDTH(16), .IN_CHANNEL(1), .KERNEL_0(1), .KERNEL_1(1), .IN_HEIGHT(4), .IN_WIDTH(4)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           fd_a     = 0;
    int           fd_b     = 0;
    int           frame [16];
    logic [143:0] got [16];
    bit           abort_f;
    logic [143:0] lit;

    always @(negedge clk) begin
        if (ifa.frame_done === 1'b1) fd_a++;
        if (ifb.frame_done === 1'b1) fd_b++;
    end

    // Expected 3x3 window w of the current frame: taps outside the 4x4 frame are zero.
    function automatic logic [143:0] exp_win(int w);
        logic [143:0] v;
        int oy, ox, y, x;
        v  = '0;
        oy = w / 4;
        ox = w % 4;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                y = oy + r - 1;
                x = ox + c - 1;
                if (y >= 0 && y < 4 && x >= 0 && x < 4)
                    v[16*(r*3+c) +: 16] = 16'(frame[y*4+x]);
            end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One frame through dut3; ack_dly 0 picks a random 1..5 cycle ack delay.
    task automatic run_frame(input int gap_pct, input int ack_dly, input int abort_at, input string name);
        int fd0;
        fd0     = fd_a;
        abort_f = 1'b0;
        fork
            begin
                int n;
                int cyc;
                n   = 0;
                cyc = 0;
                while (n < 16 && !abort_f && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (abort_f) break;
                    if (int'($urandom_range(99)) < gap_pct) begin
                        ifa.i_valid = 1'b0;
                    end else begin
                        ifa.i_valid = 1'b1;
                        ifa.i_data  = 16'(frame[n]);
                        if (ifa.i_ready === 1'b1) n++;
                    end
                end
                if (!abort_f) @(negedge clk);
                ifa.i_valid = 1'b0;
            end
            begin
                for (int w = 0; w < 16; w++) begin
                    int t;
                    int d;
                    t = 0;
                    while (ifa.o_valid !== 1'b1 && t < 300) begin
                        @(negedge clk);
                        t++;
                    end
                    n_checks++;
                    assert (t < 300) else begin
                        n_fail++;
                        $error("FAIL %s win%0d timeout: o_valid=%b expected 1", name, w, ifa.o_valid);
                    end
                    if (t >= 300) break;
                    got[w] = ifa.o_data;
                    chk($sformatf("%s win%0d", name, w), ifa.o_data, exp_win(w));
                    if (w == abort_at) begin
                        #2 rst = 1'b1;
                        #1;
                        chk($sformatf("%s async reset o_valid", name), 144'(ifa.o_valid), 144'd0);
                        abort_f = 1'b1;
                        break;
                    end
                    d = (ack_dly > 0) ? ack_dly : int'($urandom_range(1, 5));
                    for (int k = 1; k < d; k++) begin
                        @(negedge clk);
                        if (ack_dly >= 10) begin
                            chk($sformatf("%s hold win%0d data", name, w), ifa.o_data, exp_win(w));
                            chk($sformatf("%s hold win%0d vld/rdy", name, w),
                                144'({ifa.o_valid, ifa.i_ready}), 144'(2'b10));
                        end
                    end
                    ifa.pe_ack = 1'b1;
                    @(negedge clk);
                    ifa.pe_ack = 1'b0;
                end
            end
        join
        @(negedge clk);
        if (!abort_f) begin
            chk($sformatf("%s frame_done count", name), 144'(fd_a - fd0), 144'd1);
            chk($sformatf("%s idle after frame", name),
                144'({ifa.o_valid, ifa.i_ready}), 144'(2'b01));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        ifa.i_data  = '0;
        ifa.i_valid = 1'b0;
        ifa.pe_ack  = 1'b0;
        ifb.i_data  = '0;
        ifb.i_valid = 1'b0;
        ifb.pe_ack  = 1'b0;
        #12;
        chk("reset dut3 vld/done", 144'({ifa.o_valid, ifa.frame_done}), 144'd0);
        chk("reset dut3 data", ifa.o_data, 144'd0);
        chk("reset dut1 outputs", 144'({ifb.o_valid, ifb.frame_done, ifb.o_data}), 144'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset i_ready", 144'({ifa.i_ready, ifb.i_ready}), 144'(2'b11));

        // Test 1: pixels 1..16, ack after 2 cycles.
        for (int i = 0; i < 16; i++) frame[i] = i + 1;
        run_frame(0, 2, -1, "t1");
        lit = {16'd6, 16'd5, 16'd0, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        chk("t1 window0 literal", got[0], lit);
        lit = {16'd0, 16'd0, 16'd0, 16'd0, 16'd16, 16'd15, 16'd0, 16'd12, 16'd11};
        chk("t1 window15 literal", got[15], lit);

        // Test 2: ack delayed 20 cycles, window and handshake must hold.
        run_frame(0, 20, -1, "t2");

        // Test 3: 50% input gaps.
        run_frame(50, 2, -1, "t3");

        // Random pixel values, random gaps, random ack delay.
        for (int i = 0; i < 16; i++) frame[i] = int'($urandom_range(65535));
        run_frame(50, 0, -1, "trand");

        // Test 4: two frames back-to-back, second one must carry no stale data.
        for (int i = 0; i < 16; i++) frame[i] = i + 1;
        run_frame(0, 2, -1, "t4a");
        for (int i = 0; i < 16; i++) frame[i] = i + 101;
        run_frame(0, 2, -1, "t4b");
        lit = {16'd106, 16'd105, 16'd0, 16'd102, 16'd101, 16'd0, 16'd0, 16'd0, 16'd0};
        chk("t4 frame2 window0 literal", got[0], lit);

        // Test 5: reset while window 7 is presented, then a clean frame.
        for (int i = 0; i < 16; i++) frame[i] = i + 1;
        run_frame(0, 2, 7, "t5");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5 after reset", 144'({ifa.o_valid, ifa.i_ready, ifa.frame_done}), 144'(3'b010));
        run_frame(0, 2, -1, "t5b");
        chk("t5b window0 literal",  got[0],
            {16'd6, 16'd5, 16'd0, 16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0});
        chk("t5b window15 literal", got[15],
            {16'd0, 16'd0, 16'd0, 16'd0, 16'd16, 16'd15, 16'd0, 16'd12, 16'd11});

        // Test 6: 1x1 kernel, windows equal pixels; input ignored while sending; stray acks.
        for (int i = 0; i < 16; i++) frame[i] = int'($urandom_range(65535));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ifb.i_valid = 1'b1;
            ifb.i_data  = 16'(frame[i]);
            @(negedge clk);
            ifb.i_data  = 16'(frame[i] ^ 16'h5A5A);
            chk($sformatf("t6 win%0d", i),
                144'({ifb.o_valid, ifb.i_ready, ifb.o_data}), 144'({1'b1, 1'b0, 16'(frame[i])}));
            ifb.pe_ack = 1'b1;
            @(negedge clk);
            ifb.pe_ack  = 1'b0;
            ifb.i_valid = 1'b0;
            chk($sformatf("t6 after ack %0d", i),
                144'({ifb.o_valid, ifb.i_ready, ifb.frame_done}), 144'({1'b0, 1'b1, (i == 15)}));
            if ((i % 2) == 1 && i < 15) begin
                ifb.pe_ack = 1'b1;
                @(negedge clk);
                ifb.pe_ack = 1'b0;
                chk($sformatf("t6 stray ack %0d", i),
                    144'({ifb.o_valid, ifb.i_ready, ifb.frame_done}), 144'(3'b010));
            end
        end
        @(negedge clk);

        chk("total dut3 frame_done", 144'(fd_a), 144'd7);
        chk("total dut1 frame_done", 144'(fd_b), 144'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
